// File: rtl/priority_scan_encoder.sv
// Emits the index of every set bit of an accepted request vector, one per beat, in priority order.
// Optional build macro PSE_FLUSH_EN adds a flush input that abandons the vector being emitted.
module priority_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PSE_FLUSH_EN
  input  logic             flush,
`endif
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic             zero_flag;

  logic [IDX_W-1:0] idx_dec;
  logic [WIDTH-1:0] sel;
  logic             single;

  // Later loop iterations overwrite earlier ones, so the scan direction picks the winner.
  always_comb begin
    idx_dec = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pend[i]) idx_dec = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pend[i]) idx_dec = IDX_W'(i);
      end
    end
  end

  assign sel    = (pend != '0) ? (WIDTH'(1) << idx_dec) : '0;
  assign single = ((pend & (pend - WIDTH'(1))) == '0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_idx   = (state == EMIT && !zero_flag) ? idx_dec : '0;
  assign out_last  = (state == EMIT) && (zero_flag || single);
  assign out_none  = (state == EMIT) && zero_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pend      <= in_vec;
            zero_flag <= (in_vec == '0);
            state     <= EMIT;
          end
        end
        EMIT: begin
`ifdef PSE_FLUSH_EN
          if (flush) begin
            pend      <= '0;
            zero_flag <= 1'b0;
            state     <= IDLE;
          end else
`endif
          if (out_ready) begin
            if (out_last) begin
              pend      <= '0;
              zero_flag <= 1'b0;
              state     <= IDLE;
            end else begin
              pend <= pend & ~sel;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Bench for priority_scan_encoder: an 8-bit MSB-first and a 16-bit LSB-first instance against a bit-list model.
// Honours PSE_FLUSH_EN when the design is built with it.
module tb_priority_scan_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, ol8, on8;
  logic [7:0] vec8;
  logic [2:0] idx8;

  logic        iv16, ir16, ov16, or16, ol16, on16;
  logic [15:0] vec16;
  logic [3:0]  idx16;

`ifdef PSE_FLUSH_EN
  logic flush8, flush16;
`endif

  int checks   = 0;
  int failures = 0;

  priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_vec(vec8),
    .out_valid(ov8), .out_ready(or8),
`ifdef PSE_FLUSH_EN
    .flush(flush8),
`endif
    .out_idx(idx8), .out_last(ol8), .out_none(on8));

  priority_scan_encoder #(.WIDTH(16), .LSB_FIRST(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_vec(vec16),
    .out_valid(ov16), .out_ready(or16),
`ifdef PSE_FLUSH_EN
    .flush(flush16),
`endif
    .out_idx(idx16), .out_last(ol16), .out_none(on16));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int g_ir(input int w);   return w ? int'(ir16) : int'(ir8); endfunction
  function automatic int g_ov(input int w);   return w ? int'(ov16) : int'(ov8); endfunction
  function automatic int g_idx(input int w);  return w ? int'(idx16) : int'(idx8); endfunction
  function automatic int g_last(input int w); return w ? int'(ol16) : int'(ol8); endfunction
  function automatic int g_none(input int w); return w ? int'(on16) : int'(on8); endfunction

  task automatic set_in(input int w, input logic v, input logic [15:0] vec);
    if (w != 0) begin iv16 = v; vec16 = vec; end
    else begin iv8 = v; vec8 = vec[7:0]; end
  endtask

  task automatic set_rdy(input int w, input logic r);
    if (w != 0) or16 = r; else or8 = r;
  endtask

  task automatic chk_idle(input int w, input string tag);
    chk({tag, "_ready"}, g_ir(w), 1);
    chk({tag, "_valid"}, g_ov(w), 0);
    chk({tag, "_idx"},   g_idx(w), 0);
    chk({tag, "_last"},  g_last(w), 0);
    chk({tag, "_none"},  g_none(w), 0);
  endtask

  // Sends one vector and checks every beat against the list of set bits in priority order.
  task automatic send(input int w, input logic [15:0] v, input int first_stall, input int pct);
    int   q[$];
    int   width;
    bit   none;
    int   stalls;
    logic r;
    width = w ? 16 : 8;
    if (w == 0) v[15:8] = '0;
    none = (v == 16'h0);
    if (none) q.push_back(0);
    else if (w != 0) begin
      for (int i = 0; i < width; i++) if (v[i]) q.push_back(i);
    end else begin
      for (int i = width - 1; i >= 0; i--) if (v[i]) q.push_back(i);
    end
    @(negedge clk);
    chk("accept_ready", g_ir(w), 1);
    set_in(w, 1'b1, v);
    @(posedge clk);
    #1 set_in(w, 1'b0, 16'($urandom));
    for (int j = 0; j < q.size(); j++) begin
      stalls = 0;
      do begin
        @(negedge clk);
        chk("beat_valid", g_ov(w), 1);
        chk("beat_idx",   g_idx(w), q[j]);
        chk("beat_last",  g_last(w), (j == q.size() - 1) ? 1 : 0);
        chk("beat_none",  g_none(w), none ? 1 : 0);
        chk("beat_ready", g_ir(w), 0);
        if (j == 0 && stalls < first_stall) r = 1'b0;
        else if (stalls >= 8) r = 1'b1;
        else r = ($urandom_range(0, 99) >= pct);
        set_rdy(w, r);
        stalls++;
        @(posedge clk);
      end while (!r);
    end
    @(negedge clk);
    chk_idle(w, "post");
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b1, 16'hFF);
    set_in(1, 1'b1, 16'hFFFF);
    or8 = 1'b1; or16 = 1'b1;
`ifdef PSE_FLUSH_EN
    flush8 = 1'b0; flush16 = 1'b0;
`endif
    // 1: reset, with in_valid asserted to prove nothing is captured
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle(0, "rst8");
    chk_idle(1, "rst16");
    rst_n = 1'b1;
    set_in(0, 1'b0, 16'h0);
    set_in(1, 1'b0, 16'h0);

    // 2-4: directed 8-bit cases
    send(0, 16'hA4, 0, 0);
    send(0, 16'h00, 0, 0);
    send(0, 16'h81, 3, 0);
    send(0, 16'hFF, 0, 0);
    send(0, 16'h01, 0, 0);
    send(0, 16'h80, 0, 0);

    // 5: 16-bit LSB-first
    send(1, 16'h8001, 0, 0);
    send(1, 16'hFFFF, 0, 0);
    send(1, 16'h0000, 0, 0);
    send(1, 16'h8000, 2, 0);

    // 6: abort after the second beat of an all-ones vector
    @(negedge clk);
    set_in(0, 1'b1, 16'hFF);
    @(posedge clk);
    #1 set_in(0, 1'b0, 16'h0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("abort_beat", g_idx(0), 7 - j);
      or8 = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    chk("abort_pre_valid", g_ov(0), 1);
    chk("abort_pre_idx", g_idx(0), 5);
    or8 = 1'b0;
`ifdef PSE_FLUSH_EN
    flush8 = 1'b1;
`else
    rst_n = 1'b0;
`endif
    @(posedge clk);
    #1;
`ifdef PSE_FLUSH_EN
    flush8 = 1'b0;
`else
    rst_n = 1'b1;
`endif
    @(negedge clk);
    chk_idle(0, "abort");
    send(0, 16'h10, 0, 0);

    // randomized vectors with random backpressure
    for (int k = 0; k < 25; k++) send(0, 16'($urandom), 0, 40);
    for (int k = 0; k < 15; k++) send(1, 16'($urandom), 0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
